// File: rtl/fb_display_reader.sv
// fb_display_reader: 800x600@72 display timing generator that scans a
// 200x150 framebuffer with 4x pixel replication. It overlays a 9x9 cursor
// outline and drives sync, display-enable and colour pins.
//
// Pipeline (one register per stage, all controls travel with the pixel):
//   stage 0: hcnt/vcnt counters, active window, cursor hit, sync decode
//   stage 1: raddr registered, controls in s1_ctl
//   stage 2: rdata valid for the stage-1 raddr, controls in s2_ctl
//   stage 3: rgb/hs/vs/de/frame_start output registers
//
// Read path: fixed latency with no handshake. rdata is taken exactly one clk
// after raddr is registered, whatever it holds. A writer racing the reader
// simply shows up on screen, and the reader never stalls.
module fb_display_reader #(
    parameter int          H_LEN      = 200,
    parameter int          V_LEN      = 150,
    parameter int          DW         = 15,
    parameter logic [11:0] CURSOR_RGB = 12'hF00
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [11:0]   rdata,
    input  logic [7:0]    cursor_x,
    input  logic [7:0]    cursor_y,
    input  logic          cursor_en,
    output logic [DW-1:0] raddr,
    output logic          hs,
    output logic          vs,
    output logic          de,
    output logic [11:0]   rgb,
    output logic          frame_start
);

    // Visible area is the framebuffer scaled up 4x in each direction.
    localparam logic [10:0]   H_ACTIVE     = 11'(4 * H_LEN);
    localparam logic [10:0]   H_SYNC_START = 11'd856;
    localparam logic [10:0]   H_SYNC_END   = 11'd975;
    localparam logic [10:0]   H_LAST       = 11'd1039;
    localparam logic [9:0]    V_ACTIVE     = 10'(4 * V_LEN);
    localparam logic [9:0]    V_SYNC_START = 10'd637;
    localparam logic [9:0]    V_SYNC_END   = 10'd642;
    localparam logic [9:0]    V_LAST       = 10'd665;
    localparam logic [DW-1:0] H_LEN_W      = DW'(H_LEN);

    // Control bundle bit positions: {frame_start, hit, de, vs, hs}.
    localparam int C_HS  = 0;
    localparam int C_VS  = 1;
    localparam int C_DE  = 2;
    localparam int C_HIT = 3;
    localparam int C_FS  = 4;

    logic [10:0]   hcnt;
    logic [9:0]    vcnt;

    logic [7:0]    cur_x_q;
    logic [7:0]    cur_y_q;
    logic          cur_en_q;

    logic          frame_origin;
    logic          active;
    logic [7:0]    fx;
    logic [7:0]    fy;
    logic [7:0]    cur_x;
    logic [7:0]    cur_y;
    logic          cur_en;
    logic signed [8:0] dx;
    logic signed [8:0] dy;
    logic signed [8:0] adx;
    logic signed [8:0] ady;
    logic          hit;
    logic          hs0;
    logic          vs0;
    logic [DW-1:0] addr0;
    logic [4:0]    ctl0;

    logic [4:0]    s1_ctl;
    logic [4:0]    s2_ctl;

    // Raster counters: hcnt wraps every line, vcnt advances on each hcnt wrap.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
        end else begin
            hcnt <= hcnt + 11'd1;
        end
    end

    // Cursor inputs are captured only at the frame origin so one frame always
    // uses one cursor position and the outline never tears.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cur_x_q  <= '0;
            cur_y_q  <= '0;
            cur_en_q <= 1'b0;
        end else if (frame_origin) begin
            cur_x_q  <= cursor_x;
            cur_y_q  <= cursor_y;
            cur_en_q <= cursor_en;
        end
    end

    // Stage 0 decode: window, framebuffer coordinates, cursor outline, syncs.
    always_comb begin
        frame_origin = (hcnt == 11'd0) && (vcnt == 10'd0);
        active       = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE);
        fx           = hcnt[9:2];
        fy           = vcnt[9:2];

        // Pixel (0,0) already belongs to the new frame, so it uses the live
        // inputs that are being latched on this same cycle.
        cur_x  = frame_origin ? cursor_x  : cur_x_q;
        cur_y  = frame_origin ? cursor_y  : cur_y_q;
        cur_en = frame_origin ? cursor_en : cur_en_q;

        // Signed 9-bit distances. Near an edge they go negative rather than
        // wrapping, so the outline is clipped instead of reappearing opposite.
        dx  = $signed({1'b0, fx}) - $signed({1'b0, cur_x});
        dy  = $signed({1'b0, fy}) - $signed({1'b0, cur_y});
        adx = dx[8] ? -dx : dx;
        ady = dy[8] ? -dy : dy;

        hit = cur_en && active
              && (adx <= 9'sd4) && (ady <= 9'sd4)
              && ((adx == 9'sd4) || (ady == 9'sd4));

        hs0   = (hcnt >= H_SYNC_START) && (hcnt <= H_SYNC_END);
        vs0   = (vcnt >= V_SYNC_START) && (vcnt <= V_SYNC_END);
        addr0 = active ? (DW'(fy) * H_LEN_W + DW'(fx)) : '0;

        ctl0        = '0;
        ctl0[C_HS]  = hs0;
        ctl0[C_VS]  = vs0;
        ctl0[C_DE]  = active;
        ctl0[C_HIT] = hit;
        ctl0[C_FS]  = frame_origin;
    end

    // Stages 1 and 2: issue the read address, then carry controls alongside
    // the read so they meet rdata on the same cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            raddr  <= '0;
            s1_ctl <= '0;
            s2_ctl <= '0;
        end else begin
            raddr  <= addr0;
            s1_ctl <= ctl0;
            s2_ctl <= s1_ctl;
        end
    end

    // Stage 3: all pins come out of one register rank. Colour is forced to
    // black outside the visible window.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            hs          <= 1'b0;
            vs          <= 1'b0;
            de          <= 1'b0;
            frame_start <= 1'b0;
            rgb         <= '0;
        end else begin
            hs          <= s2_ctl[C_HS];
            vs          <= s2_ctl[C_VS];
            de          <= s2_ctl[C_DE];
            frame_start <= s2_ctl[C_FS];
            if (!s2_ctl[C_DE]) begin
                rgb <= '0;
            end else if (s2_ctl[C_HIT]) begin
                rgb <= CURSOR_RGB;
            end else begin
                rgb <= rdata;
            end
        end
    end

endmodule

// File: tb/tb_fb_display_reader.sv
// tb_fb_display_reader: directed checks of the display reader. A framebuffer
// model returns mem[a] = a[11:0] one clk after raddr. A counter model marks
// which raster position the DUT is on, so the pin values can be checked
// against hand-computed pixels.
module tb_fb_display_reader;

    localparam int DW = 15;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [11:0]   rdata = '0;
    logic [7:0]    cursor_x = '0;
    logic [7:0]    cursor_y = '0;
    logic          cursor_en = 1'b0;
    logic [DW-1:0] raddr;
    logic          hs;
    logic          vs;
    logic          de;
    logic [11:0]   rgb;
    logic          frame_start;

    logic force_fff = 1'b0;
    int   hc = 0;
    int   vc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   timed_out = 1'b0;

    // Clock / reset block.
    always #10 clk = ~clk;

    fb_display_reader #(
        .H_LEN(200), .V_LEN(150), .DW(DW), .CURSOR_RGB(12'hF00)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .rdata      (rdata),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y),
        .cursor_en  (cursor_en),
        .raddr      (raddr),
        .hs         (hs),
        .vs         (vs),
        .de         (de),
        .rgb        (rgb),
        .frame_start(frame_start)
    );

    // Framebuffer model: registered read, optionally overridden with white.
    always @(posedge clk) rdata <= force_fff ? 12'hFFF : raddr[11:0];

    // Reference raster position: the counter value the DUT is currently on.
    always @(posedge clk) begin
        if (!rstn) begin
            hc <= 0;
            vc <= 0;
        end else if (hc == 1039) begin
            hc <= 0;
            vc <= (vc == 665) ? 0 : vc + 1;
        end else begin
            hc <= hc + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (hc=%0d vc=%0d)", tag, got, exp, hc, vc);
        end
    endtask

    // Wait (at a negedge) until the raster counter sits at (h,v).
    task automatic goto_pos(input int h, input int v);
        int budget;
        budget = 0;
        if (timed_out) return;
        while (!(hc == h && vc == v)) begin
            @(negedge clk);
            budget++;
            if (budget > 50000) begin
                timed_out = 1'b1;
                n_checks++;
                n_errors++;
                $display("FAIL timeout waiting for hc=%0d vc=%0d", h, v);
                return;
            end
        end
    endtask

    // Pins show the pixel three counter positions back.
    task automatic check_rgb(input string tag, input int h_out, input int v, input logic [11:0] exp);
        goto_pos(h_out + 3, v);
        check_eq(tag, rgb, exp);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_raddr"}, raddr, 0);
        check_eq({tag, "_hs"}, hs, 0);
        check_eq({tag, "_vs"}, vs, 0);
        check_eq({tag, "_de"}, de, 0);
        check_eq({tag, "_rgb"}, rgb, 0);
        check_eq({tag, "_fs"}, frame_start, 0);
    endtask

    // Release reset at a negedge; frame_start must appear on the third edge.
    task automatic release_reset();
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("frame_start", frame_start, (i == 2) ? 1 : 0);
            if (i == 2) check_eq("de_first_pixel", de, 1);
        end
    endtask

    initial begin
        // Frame 1 cursor, captured at the first frame origin after release.
        cursor_x  = 8'd20;
        cursor_y  = 8'd4;
        cursor_en = 1'b1;
        rstn      = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        release_reset();

        // Mid-frame cursor move: must not show until the next frame.
        cursor_x = 8'd2;
        cursor_y = 8'd2;

        // fy=0 is the top edge of the (20,4) outline: fx 16..24 red.
        check_rgb("row0_fx15", 60, 0, 12'h00F);
        check_rgb("row0_fx16", 64, 0, 12'hF00);
        check_rgb("row0_fx20", 80, 0, 12'hF00);
        check_rgb("row0_fx24", 99, 0, 12'hF00);
        check_rgb("row0_fx25", 100, 0, 12'h019);

        goto_pos(802, 0);
        check_eq("de_last_active", de, 1);
        goto_pos(803, 0);
        check_eq("de_first_blank", de, 0);
        check_eq("rgb_first_blank", rgb, 0);

        goto_pos(850, 0);
        force_fff = 1'b1;
        goto_pos(858, 0);
        check_eq("hs_855", hs, 0);
        goto_pos(859, 0);
        check_eq("hs_856", hs, 1);
        goto_pos(901, 0);
        check_eq("raddr_blank_900", raddr, 0);
        goto_pos(903, 0);
        check_eq("rgb_blank_900", rgb, 0);
        check_eq("de_blank_900", de, 0);
        goto_pos(978, 0);
        check_eq("hs_975", hs, 1);
        goto_pos(979, 0);
        check_eq("hs_976", hs, 0);
        goto_pos(1000, 0);
        force_fff = 1'b0;
        goto_pos(858, 1);
        check_eq("hs_line1_855", hs, 0);
        goto_pos(859, 1);
        check_eq("hs_line1_856", hs, 1);

        // Pattern read at hcnt=13, vcnt=9: fx=3, fy=2.
        goto_pos(14, 9);
        check_eq("raddr_13_9", raddr, 403);
        check_eq("rgb_fx2_fy2", rgb, 12'h192);
        for (int h = 12; h <= 15; h++) check_rgb("rgb_fx3_fy2", h, 9, 12'h193);
        check_rgb("rgb_fx4_fy2", 16, 9, 12'h194);

        // fy=4 is the centre row: only fx 16 and 24 are outline.
        check_rgb("row4_fx15", 60, 16, 12'h32F);
        check_rgb("row4_fx16", 64, 16, 12'hF00);
        check_rgb("row4_fx17", 68, 16, 12'h331);
        check_rgb("row4_centre", 80, 16, 12'h334);
        check_rgb("row4_fx24", 96, 16, 12'hF00);
        check_rgb("row4_fx25", 100, 16, 12'h339);

        // fy=6: old cursor still in force (new one would paint fx=0 red).
        check_rgb("row6_fx0_old_cursor", 0, 24, 12'h4B0);
        check_rgb("row6_fx16", 64, 24, 12'hF00);

        // fy=8 bottom edge, fy=9 just outside.
        check_rgb("row8_fx20", 80, 32, 12'hF00);
        check_rgb("row8_fx25", 100, 32, 12'h659);

        // One-clk reset in the middle of an active line.
        goto_pos(400, 33);
        check_eq("de_before_reset", de, 1);
        rstn = 1'b0;
        @(negedge clk);
        check_all_zero("midframe_reset");
        release_reset();

        // Frame 2: cursor (2,2) now in force, clipped at the left/top.
        check_rgb("f2_row0_fx6", 24, 0, 12'hF00);
        check_rgb("f2_row0_fx7", 28, 0, 12'h007);
        check_rgb("f2_row2_fx0", 0, 8, 12'h190);
        check_rgb("f2_row2_fx6", 24, 8, 12'hF00);
        check_rgb("f2_row2_fx198", 792, 8, 12'h256);
        check_rgb("f2_row2_fx199", 796, 8, 12'h257);
        check_rgb("f2_row6_fx0", 0, 24, 12'hF00);
        check_rgb("f2_row6_fx6", 24, 24, 12'hF00);
        check_rgb("f2_row6_fx7", 28, 24, 12'h4B7);
        check_rgb("f2_row6_fx199", 796, 24, 12'h577);

        // Reset during the hsync pulse: sync must drop immediately.
        goto_pos(900, 25);
        check_eq("hs_before_reset", hs, 1);
        rstn      = 1'b0;
        cursor_en = 1'b0;
        @(negedge clk);
        check_all_zero("hsync_reset");
        release_reset();

        // Frame 3: cursor disabled, the former outline pixels show rdata.
        check_rgb("f3_row0_fx6", 24, 0, 12'h006);
        check_rgb("f3_row0_fx7", 28, 0, 12'h007);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
